// File: rtl/reg_file_param_pkg.sv
// Shared types and defaults for the parametrised register file and its soft-clear sequencer.
// The clear-FSM state encoding is fixed so that both files agree on it.
package reg_file_param_pkg;

  localparam int RF_DEF_WIDTH = 16;
  localparam int RF_DEF_DEPTH = 8;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/reg_file_param_clear_seq.sv
// Soft-clear sequencer: sweeps every register address once, one per cycle, and
// drives the array's clear write port while the sweep is in progress.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  RF_IDLE  | no sweep; a clr pulse starts one with the counter at 0
//  RF_CLEAR | zeroing register cnt this cycle; leaves after cnt==DEPTH-1
module rf_clear_seq
  import reg_file_param_pkg::*;
#(
  parameter int DEPTH  = RF_DEF_DEPTH,
  parameter int ADDR_W = $clog2(RF_DEF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  rf_state_e         state, state_next;
  logic [ADDR_W-1:0] cnt, cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RF_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      RF_IDLE: begin
        if (clr) begin
          state_next = RF_CLEAR;
          cnt_next   = '0;
        end
      end
      RF_CLEAR: begin
        // clr is deliberately ignored here; a new pulse never restarts the sweep
        if (cnt == LAST) begin
          state_next = RF_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + ADDR_W'(1);
        end
      end
      default: begin
        state_next = RF_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign busy     = (state == RF_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised CPU register file: two registered read ports, one write port,
// optional write-to-read bypass, optional hardwired-zero R0 and a sequenced soft clear.
module reg_file_param
  import reg_file_param_pkg::*;
#(
  parameter  int WIDTH   = RF_DEF_WIDTH,
  parameter  int DEPTH   = RF_DEF_DEPTH,
  parameter  int BYPASS  = 1,
  parameter  int ZERO_R0 = 0,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_en,
  input  logic              I_we,
  input  logic [ADDR_W-1:0] I_selA,
  input  logic [ADDR_W-1:0] I_selB,
  input  logic [ADDR_W-1:0] I_selD,
  input  logic [WIDTH-1:0]  I_dataD,
  input  logic              I_clr,
  output logic [WIDTH-1:0]  O_dataA,
  output logic [WIDTH-1:0]  O_dataB,
  output logic              O_busy
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  regs [DEPTH];
  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_fire;
  logic              fwd_a, fwd_b;
  logic [WIDTH-1:0]  rd_a, rd_b;

  rf_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (I_clk),
    .rst      (I_rst),
    .clr      (I_clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  function automatic logic sel_ok(input logic [ADDR_W-1:0] sel);
    return ({1'b0, sel} < DEPTH_L);
  endfunction

  function automatic logic is_r0_zero(input logic [ADDR_W-1:0] sel);
    return (ZERO_R0 != 0) && (sel == '0);
  endfunction

  // Out-of-range selects and a hardwired R0 win over both forwarding and array contents.
  function automatic logic [WIDTH-1:0] read_mux(input logic [ADDR_W-1:0] sel,
                                                input logic [WIDTH-1:0]  cur,
                                                input logic              fwd,
                                                input logic [WIDTH-1:0]  fwd_data);
    if (!sel_ok(sel) || is_r0_zero(sel)) return '0;
    if (fwd) return fwd_data;
    return cur;
  endfunction

  assign wr_fire = I_en && I_we && !busy && sel_ok(I_selD) && !is_r0_zero(I_selD);

  // busy already blocks wr_fire, so no forwarding can happen during a sweep.
  assign fwd_a = (BYPASS != 0) && wr_fire && (I_selA == I_selD);
  assign fwd_b = (BYPASS != 0) && wr_fire && (I_selB == I_selD);

  assign rd_a = read_mux(I_selA, regs[I_selA], fwd_a, I_dataD);
  assign rd_b = read_mux(I_selB, regs[I_selB], fwd_b, I_dataD);

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (clr_we) begin
      regs[clr_addr] <= '0;
    end else if (wr_fire) begin
      regs[I_selD] <= I_dataD;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      O_dataA <= '0;
      O_dataB <= '0;
    end else if (I_en) begin
      O_dataA <= rd_a;
      O_dataB <= rd_b;
    end
  end

  assign O_busy = busy;

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: one default instance (BYPASS=1, DEPTH=8) and one
// with BYPASS=0, ZERO_R0=1, DEPTH=6, both driven by the same directed vectors.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        rst, en, we, clr;
  logic [2:0]  sel_a, sel_b, sel_d;
  logic [15:0] data_d;
  logic [15:0] a0, b0, a1, b1;
  logic        y0, y1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [15:0] a0, b0, a1, b1;
    logic        y0, y1;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  reg_file_param #(.WIDTH(16), .DEPTH(8), .BYPASS(1), .ZERO_R0(0)) dut0 (
    .I_clk(clk), .I_rst(rst), .I_en(en), .I_we(we),
    .I_selA(sel_a), .I_selB(sel_b), .I_selD(sel_d), .I_dataD(data_d), .I_clr(clr),
    .O_dataA(a0), .O_dataB(b0), .O_busy(y0)
  );

  reg_file_param #(.WIDTH(16), .DEPTH(6), .BYPASS(0), .ZERO_R0(1)) dut1 (
    .I_clk(clk), .I_rst(rst), .I_en(en), .I_we(we),
    .I_selA(sel_a), .I_selB(sel_b), .I_selD(sel_d), .I_dataD(data_d), .I_clr(clr),
    .O_dataA(a1), .O_dataB(b1), .O_busy(y1)
  );

  task automatic chk(input string nm, input string fld, input logic [15:0] act,
                     input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h", nm, fld, act, req);
    end
  endtask

  // Monitor: outputs settle after each posedge; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "a0", a0, e.a0);
        chk(e.name, "b0", b0, e.b0);
        chk(e.name, "busy0", {15'd0, y0}, {15'd0, e.y0});
        chk(e.name, "a1", a1, e.a1);
        chk(e.name, "b1", b1, e.b1);
        chk(e.name, "busy1", {15'd0, y1}, {15'd0, e.y1});
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic e, input logic w,
                      input logic [2:0] sa, input logic [2:0] sb, input logic [2:0] sd,
                      input logic [15:0] d, input logic c,
                      input logic [15:0] ea0, input logic [15:0] eb0, input logic ey0,
                      input logic [15:0] ea1, input logic [15:0] eb1, input logic ey1);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; we = w; sel_a = sa; sel_b = sb; sel_d = sd; data_d = d; clr = c;
    x.name = nm; x.a0 = ea0; x.b0 = eb0; x.y0 = ey0; x.a1 = ea1; x.b1 = eb1; x.y1 = ey1;
    exp_q.push_back(x);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; we = 1'b0; clr = 1'b0;
    sel_a = '0; sel_b = '0; sel_d = '0; data_d = '0;

    // Reset with junk on every input, including a clear request.
    step("reset", 1, 1, 1, 3, 5, 3, 16'hFFFF, 1, 16'h0, 16'h0, 0, 16'h0, 16'h0, 0);
    for (int i = 0; i < 4; i++)
      step("rd_after_rst", 0, 1, 0, 3'(i), 3'(7 - i), 0, 16'h0, 0,
           16'h0, 16'h0, 0, 16'h0, 16'h0, 0);

    step("wr_r3", 0, 1, 1, 0, 0, 3, 16'hA5A5, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 0);
    step("rd_r3", 0, 1, 0, 3, 3, 0, 16'h0, 0, 16'hA5A5, 16'hA5A5, 0, 16'hA5A5, 16'hA5A5, 0);

    step("bypass_r5", 0, 1, 1, 5, 5, 5, 16'h1234, 0, 16'h1234, 16'h1234, 0, 16'h0, 16'h0, 0);
    step("rd_r5_r3", 0, 1, 0, 5, 3, 0, 16'h0, 0, 16'h1234, 16'hA5A5, 0, 16'h1234, 16'hA5A5, 0);

    step("wr_r0", 0, 1, 1, 0, 0, 0, 16'hFFFF, 0, 16'hFFFF, 16'hFFFF, 0, 16'h0, 16'h0, 0);
    step("rd_r0", 0, 1, 0, 0, 0, 0, 16'h0, 0, 16'hFFFF, 16'hFFFF, 0, 16'h0, 16'h0, 0);
    step("wr_sel7", 0, 1, 1, 7, 6, 7, 16'hBEEF, 0, 16'hBEEF, 16'h0, 0, 16'h0, 16'h0, 0);
    step("rd_sel7", 0, 1, 0, 7, 6, 0, 16'h0, 0, 16'hBEEF, 16'h0, 0, 16'h0, 16'h0, 0);

    step("en_low_hold", 0, 0, 1, 0, 0, 3, 16'h0000, 0, 16'hBEEF, 16'h0, 0, 16'h0, 16'h0, 0);
    step("rd_r3_kept", 0, 1, 0, 3, 3, 0, 16'h0, 0, 16'hA5A5, 16'hA5A5, 0, 16'hA5A5, 16'hA5A5, 0);

    for (int i = 1; i < 8; i++)
      step("fill", 0, 1, 1, 0, 0, 3'(i), 16'h1000 + 16'(i), 0,
           16'hFFFF, 16'hFFFF, 0, 16'h0, 16'h0, 0);

    // Clear request on the same edge as a write: write lands, sweep starts.
    step("clr_start", 0, 1, 1, 2, 2, 2, 16'h2222, 1, 16'h2222, 16'h2222, 1, 16'h1002, 16'h1002, 1);
    for (int j = 1; j <= 8; j++)
      step("clr_sweep", 0, 1, (j <= 6) ? 1'b1 : 1'b0, 7, 1, 1, 16'hEEEE, (j == 3) ? 1'b1 : 1'b0,
           16'h1007, (j <= 2) ? 16'h1001 : 16'h0, (j <= 7) ? 1'b1 : 1'b0,
           16'h0, (j <= 2) ? 16'h1001 : 16'h0, (j <= 5) ? 1'b1 : 1'b0);
    for (int i = 0; i < 8; i++)
      step("rd_after_clr", 0, 1, 0, 3'(i), 3'(7 - i), 0, 16'h0, 0,
           16'h0, 16'h0, 0, 16'h0, 16'h0, 0);

    step("wr_r4", 0, 1, 1, 0, 0, 4, 16'h4444, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 0);
    step("clr2_start", 0, 1, 0, 4, 4, 0, 16'h0, 1, 16'h4444, 16'h4444, 1, 16'h4444, 16'h4444, 1);
    step("clr2_busy1", 0, 1, 0, 4, 4, 0, 16'h0, 0, 16'h4444, 16'h4444, 1, 16'h4444, 16'h4444, 1);
    step("clr2_busy2", 0, 1, 0, 4, 4, 0, 16'h0, 0, 16'h4444, 16'h4444, 1, 16'h4444, 16'h4444, 1);
    step("rst_mid_clr", 1, 1, 1, 4, 4, 5, 16'h5555, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 0);
    step("rd_after_rst2", 0, 1, 0, 4, 5, 0, 16'h0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 0);
    step("wr_r6", 0, 1, 1, 6, 4, 6, 16'h6666, 0, 16'h6666, 16'h0, 0, 16'h0, 16'h0, 0);
    step("rd_r6", 0, 1, 0, 6, 6, 0, 16'h0, 0, 16'h6666, 16'h6666, 0, 16'h0, 16'h0, 0);
    step("wr_r3b", 0, 1, 1, 3, 3, 3, 16'h3333, 0, 16'h3333, 16'h3333, 0, 16'h0, 16'h0, 0);
    step("rd_r3_r6", 0, 1, 0, 3, 6, 0, 16'h0, 0, 16'h3333, 16'h6666, 0, 16'h3333, 16'h0, 0);

    @(negedge clk);
    en = 1'b0; we = 1'b0; clr = 1'b0;
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
